turn_sequencer: RTL and testbench
=================================

# turn_sequencer

Parametrised turn sequencer for the board-game datapath; successor to the two-player black/white toggle. Tracks whose turn it is among NUM_PLAYERS players and drives that player's board colour to the drawing logic. Adds explicit pass handling, an optional per-turn tick timer (expiry is a forced pass), game-over detection when every player passes in a row, and a completed-move counter. Sits between the move/flip controller, which reports turn completion, and the VGA colour path.

## Interface
- NUM_PLAYERS, default 2: number of players, 2..8.
- COLOUR_W, default 3: width of one colour entry.
- PLAYER_COLOURS, default {3'b111, 3'b000}: packed colour table, NUM_PLAYERS×COLOUR_W; player k uses bits [k*COLOUR_W +: COLOUR_W] (default: player 0 = 000 black, player 1 = 111 white).
- TIMEOUT_TICKS, default 0: ticks allowed per turn; 0 disables the timer.
- TW, default 8: timer width; TIMEOUT_TICKS < 2^TW.
- PW (derived) = max(1, $clog2(NUM_PLAYERS)).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-high reset.
- turn_done  in  1  current player has finished a move and all flips are complete; single-cycle strobe.
- turn_pass  in  1  current player has no legal move; single-cycle strobe.
- tick  in  1  timer enable strobe, e.g. 1 Hz.
- new_game  in  1  synchronous restart.
- player  out  PW  index of the player to move.
- player_colour  out  COLOUR_W  PLAYER_COLOURS entry for player.
- time_left  out  TW  remaining ticks this turn.
- turn_count  out  8  completed moves (passes excluded), wraps 255→0.
- turn_start  out  1  one-cycle pulse when a new turn begins.
- timeout  out  1  one-cycle pulse when the timer forces a pass.
- game_over  out  1  level, high in OVER.

## Operation
- FSM with two states: PLAY and OVER. Reset enters PLAY.
- Reset values: player=0, player_colour=PLAYER_COLOURS[0], time_left=TIMEOUT_TICKS, turn_count=0, internal pass_cnt=0, turn_start=0, timeout=0, game_over=0.
- Events in PLAY, one per cycle, in priority order: new_game > turn_done > turn_pass > timer expiry.
- Advance: player ← (player == NUM_PLAYERS-1) ? 0 : player+1. time_left reloads to TIMEOUT_TICKS. turn_start pulses.
- turn_done: advance; turn_count+1; pass_cnt ← 0.
- turn_pass: advance; pass_cnt+1.
- Timer expiry happens when TIMEOUT_TICKS≠0, tick=1, time_left==1, and neither turn_done nor turn_pass is asserted. Handled as a pass; timeout pulses.
- Otherwise, tick with TIMEOUT_TICKS≠0 decrements time_left. With TIMEOUT_TICKS=0, tick is ignored and time_left stays 0.
- When a pass makes pass_cnt == NUM_PLAYERS: enter OVER, game_over=1. player still advances. No turn_start pulse.
- OVER: turn_done, turn_pass and tick are ignored; all outputs hold.
- new_game, in either state: all registers return to reset values except turn_start, which pulses. State goes to PLAY.
- turn_done together with turn_pass: done wins and the pass is dropped.
- player_colour is a registered lookup of the next player, aligned with player.

## Timing
- All inputs are sampled on the rising edge of clk. All outputs are registered.
- Latency is 1 cycle: an event at edge N is visible on player, player_colour and pulses after edge N. Pulses are high for exactly one cycle.
- Back-to-back strobes on consecutive cycles each advance the turn. No dead cycle is required.
- resetn assertion clears all outputs immediately, independent of clk. It applies mid-turn and in OVER. Release is synchronised by the surrounding design.
- time_left reload and decrement never underflow. The value stays in 1..TIMEOUT_TICKS while in PLAY.

## Test plan
- Default params, reset, then 3 turn_done strobes: player 0→1→0→1, colour 000→111→000→111, turn_count=3, one turn_start pulse per strobe.
- NUM_PLAYERS=3, turn_pass then turn_done then turn_pass ×3: no game_over after the first pass (pass_cnt cleared by done). game_over=1 after the third consecutive pass. Further strobes ignored.
- TIMEOUT_TICKS=3, 3 ticks with no move: time_left 3→2→1, then timeout pulse, player advances, time_left=3.
- Same cycle turn_done+tick at time_left=1: no timeout, turn_count+1. Same cycle turn_done+turn_pass: treated as done only.
- In OVER, new_game: game_over=0, player=0, turn_count=0, turn_start pulse. Async resetn mid-turn between clk edges: outputs reset without waiting for an edge.
- 256 turn_done strobes: turn_count wraps to 0.

Source files
------------

// File: rtl/turn_sequencer_if.sv
// Turn-sequencer bus: move-controller strobes in, turn/colour/timer status out.
interface turn_sequencer_if #(
  parameter int unsigned PW       = 1,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned TW       = 8
);
  logic                turn_done;
  logic                turn_pass;
  logic                tick;
  logic                new_game;
  logic [PW-1:0]       player;
  logic [COLOUR_W-1:0] player_colour;
  logic [TW-1:0]       time_left;
  logic [7:0]          turn_count;
  logic                turn_start;
  logic                timeout;
  logic                game_over;

  modport master (
    output turn_done, turn_pass, tick, new_game,
    input  player, player_colour, time_left, turn_count, turn_start, timeout, game_over
  );

  modport slave (
    input  turn_done, turn_pass, tick, new_game,
    output player, player_colour, time_left, turn_count, turn_start, timeout, game_over
  );
endinterface

// File: rtl/turn_sequencer.sv
// Multi-player turn sequencer: pass handling, optional per-turn tick timer,
// game-over on a full round of consecutive passes, completed-move counter.
module turn_sequencer #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned COLOUR_W    = 3,
  parameter logic [NUM_PLAYERS*COLOUR_W-1:0] PLAYER_COLOURS = {3'b111, 3'b000},
  parameter int unsigned TIMEOUT_TICKS = 0,
  parameter int unsigned TW            = 8
) (
  input  logic               clk,
  input  logic               resetn,
  turn_sequencer_if.slave    bus
);

  localparam int unsigned PW       = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned PCW      = $clog2(NUM_PLAYERS + 1);
  localparam int unsigned ROM_N    = 1 << PW;
  localparam logic [TW-1:0] TL_RELOAD = TW'(TIMEOUT_TICKS);
  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [PCW-1:0] ALL_PASSED = PCW'(NUM_PLAYERS);
  localparam bit TIMER_ON = (TIMEOUT_TICKS != 0);

  typedef enum logic {S_PLAY = 1'b0, S_OVER = 1'b1} state_t;

  state_t              r_state, w_state;
  logic [PW-1:0]       r_player, w_player, w_player_adv;
  logic [COLOUR_W-1:0] r_colour;
  logic [TW-1:0]       r_time_left, w_time_left;
  logic [7:0]          r_turn_count, w_turn_count;
  logic [PCW-1:0]      r_pass_cnt, w_pass_cnt;
  logic                r_turn_start, w_turn_start;
  logic                r_timeout, w_timeout;
  logic                w_pass_event;
  logic [COLOUR_W-1:0] w_rom [ROM_N];

  // Colour table padded to a power of two so any player index is in range
  for (genvar g = 0; g < ROM_N; g++) begin : g_rom
    if (g < NUM_PLAYERS) begin : g_used
      assign w_rom[g] = PLAYER_COLOURS[g*COLOUR_W +: COLOUR_W];
    end else begin : g_pad
      assign w_rom[g] = '0;
    end
  end

  assign w_player_adv = (r_player == LAST_PLAYER) ? '0 : r_player + PW'(1);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state      <= S_PLAY;
      r_player     <= '0;
      r_colour     <= PLAYER_COLOURS[COLOUR_W-1:0];
      r_time_left  <= TL_RELOAD;
      r_turn_count <= '0;
      r_pass_cnt   <= '0;
      r_turn_start <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_player     <= w_player;
      r_colour     <= w_rom[w_player];
      r_time_left  <= w_time_left;
      r_turn_count <= w_turn_count;
      r_pass_cnt   <= w_pass_cnt;
      r_turn_start <= w_turn_start;
      r_timeout    <= w_timeout;
    end
  end

  // One event per cycle: new_game > turn_done > turn_pass > timer expiry
  always_comb begin
    w_state      = r_state;
    w_player     = r_player;
    w_time_left  = r_time_left;
    w_turn_count = r_turn_count;
    w_pass_cnt   = r_pass_cnt;
    w_turn_start = 1'b0;
    w_timeout    = 1'b0;
    w_pass_event = 1'b0;

    if (bus.new_game) begin
      w_state      = S_PLAY;
      w_player     = '0;
      w_time_left  = TL_RELOAD;
      w_turn_count = '0;
      w_pass_cnt   = '0;
      w_turn_start = 1'b1;
    end else begin
      case (r_state)
        S_PLAY: begin
          if (bus.turn_done) begin
            w_player     = w_player_adv;
            w_time_left  = TL_RELOAD;
            w_turn_count = r_turn_count + 8'd1;
            w_pass_cnt   = '0;
            w_turn_start = 1'b1;
          end else if (bus.turn_pass) begin
            w_pass_event = 1'b1;
          end else if (TIMER_ON && bus.tick) begin
            if (r_time_left == TW'(1)) begin
              w_pass_event = 1'b1;
              w_timeout    = 1'b1;
            end else begin
              w_time_left = r_time_left - TW'(1);
            end
          end

          // A full round of passes ends the game without starting a new turn
          if (w_pass_event) begin
            w_player    = w_player_adv;
            w_time_left = TL_RELOAD;
            w_pass_cnt  = r_pass_cnt + PCW'(1);
            if (w_pass_cnt == ALL_PASSED) begin
              w_state = S_OVER;
            end else begin
              w_turn_start = 1'b1;
            end
          end
        end
        S_OVER: begin
        end
        default: w_state = S_PLAY;
      endcase
    end
  end

  assign bus.player        = r_player;
  assign bus.player_colour = r_colour;
  assign bus.time_left     = r_time_left;
  assign bus.turn_count    = r_turn_count;
  assign bus.turn_start    = r_turn_start;
  assign bus.timeout       = r_timeout;
  assign bus.game_over     = (r_state == S_OVER);

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: 3 players, 3-tick turn timer.
module tb_turn_sequencer;

  localparam int unsigned NP   = 3;
  localparam int unsigned CW   = 3;
  localparam int unsigned TT   = 3;
  localparam int unsigned TWID = 8;
  localparam int unsigned PWID = 2;

  logic clk = 1'b0;
  logic resetn = 1'b1;

  turn_sequencer_if #(.PW(PWID), .COLOUR_W(CW), .TW(TWID)) bus();

  turn_sequencer #(
    .NUM_PLAYERS   (NP),
    .COLOUR_W      (CW),
    .PLAYER_COLOURS(9'b101_111_000),
    .TIMEOUT_TICKS (TT),
    .TW            (TWID)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    player;
    int    colour;
    int    tl;
    int    cnt;
    int    ts;
    int    to;
    int    over;
    string tag;
  } exp_t;

  exp_t q[$];
  int   m_player, m_tl, m_cnt, m_pass, m_over, m_ts, m_to;
  bit   stim_done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic int colour_of(int p);
    case (p)
      0:       return 0;   // 3'b000
      1:       return 7;   // 3'b111
      default: return 5;   // 3'b101
    endcase
  endfunction

  task automatic model_reset();
    m_player = 0; m_tl = TT; m_cnt = 0; m_pass = 0;
    m_over = 0; m_ts = 0; m_to = 0;
  endtask

  task automatic model_step(bit d, bit p, bit t, bit n);
    bit pe;
    pe   = 1'b0;
    m_ts = 0;
    m_to = 0;
    if (n) begin
      model_reset();
      m_ts = 1;
    end else if (!m_over) begin
      if (d) begin
        m_player = (m_player + 1) % NP;
        m_tl     = TT;
        m_cnt    = (m_cnt + 1) % 256;
        m_pass   = 0;
        m_ts     = 1;
      end else if (p) begin
        pe = 1'b1;
      end else if (t) begin
        if (m_tl == 1) begin
          pe   = 1'b1;
          m_to = 1;
        end else begin
          m_tl = m_tl - 1;
        end
      end
      if (pe) begin
        m_player = (m_player + 1) % NP;
        m_tl     = TT;
        m_pass   = m_pass + 1;
        if (m_pass == NP) m_over = 1;
        else              m_ts   = 1;
      end
    end
  endtask

  task automatic push(string tag);
    exp_t e;
    e.player = m_player; e.colour = colour_of(m_player); e.tl = m_tl;
    e.cnt = m_cnt; e.ts = m_ts; e.to = m_to; e.over = m_over; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic step(bit d, bit p, bit t, bit n, string tag);
    bus.turn_done = d; bus.turn_pass = p; bus.tick = t; bus.new_game = n;
    @(posedge clk);
    #1;
    bus.turn_done = 1'b0; bus.turn_pass = 1'b0; bus.tick = 1'b0; bus.new_game = 1'b0;
    model_step(d, p, t, n);
    push(tag);
  endtask

  // Stimulus: directed sequences; expectations queued for the monitor
  initial begin
    bus.turn_done = 1'b0; bus.turn_pass = 1'b0; bus.tick = 1'b0; bus.new_game = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    push("reset");
    resetn = 1'b0;

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "done_seq");

    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "timeout_seq");

    step(0, 0, 1, 0, "tick_a");
    step(0, 0, 1, 0, "tick_b");
    step(1, 0, 1, 0, "done_tick_tl1");
    step(1, 1, 0, 0, "done_pass");

    step(0, 1, 0, 0, "pass1");
    step(1, 0, 0, 0, "done_clears");
    step(0, 1, 0, 0, "pass_a");
    step(0, 1, 0, 0, "pass_b");
    step(0, 1, 0, 0, "pass_c_over");
    step(1, 0, 0, 0, "over_done");
    step(0, 1, 0, 0, "over_pass");
    step(0, 0, 1, 0, "over_tick");
    step(0, 0, 0, 1, "newgame_over");

    step(0, 1, 0, 0, "tp1");
    step(0, 1, 0, 0, "tp2");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "timeout_over");
    step(0, 0, 0, 1, "newgame2");

    step(1, 0, 0, 0, "pre_rst_done");
    step(0, 0, 1, 0, "pre_rst_tick");
    @(posedge clk);
    #1;
    model_reset();
    push("async_rst");
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    push("rst_held");
    resetn = 1'b0;

    for (int i = 0; i < 256; i++) step(1, 0, 0, 0, "wrap");
    step(0, 0, 0, 0, "idle_end");
    stim_done = 1'b1;
  end

  task automatic chk(string tag, string what, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", tag, what, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle, sampled on the falling edge
  initial begin : monitor
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "player",     int'(bus.player),        e.player);
        chk(e.tag, "colour",     int'(bus.player_colour), e.colour);
        chk(e.tag, "time_left",  int'(bus.time_left),     e.tl);
        chk(e.tag, "turn_count", int'(bus.turn_count),    e.cnt);
        chk(e.tag, "turn_start", int'(bus.turn_start),    e.ts);
        chk(e.tag, "timeout",    int'(bus.timeout),       e.to);
        chk(e.tag, "game_over",  int'(bus.game_over),     e.over);
      end
      if (stim_done && q.size() == 0) break;
      if (cyc > 5000) begin
        checks++;
        errors++;
        $display("FAIL watchdog: got %0d pending expected 0", q.size());
        break;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
